hart_mem_arbiter: RTL and testbench

- Sits directly downstream of the hart top. Merges the hart's instruction-fetch port (IC) and data port (DM) onto one shared single-ported memory bus.
- Grants one master at a time and registers the granted request.
- Drives the memory handshake, then returns a one-cycle ready pulse with registered read data to the granted master.

---
 rtl/arvi_arb_pkg.sv | 7 +
 rtl/hart_arb_picker.sv | 26 ++
 rtl/hart_mem_arbiter.sv | 85 ++++++++
 tb/tb_hart_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arvi_arb_pkg.sv
// arvi_arb_pkg: shared types and constants for the hart memory arbiter
package arvi_arb_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;
   typedef enum logic {M_IC, M_DM} arb_master_t;
   localparam int MAX_BE_W = 64;
   localparam logic [MAX_BE_W-1:0] BE_ALL_ONES = '1;
endpackage

// File: rtl/hart_arb_picker.sv
// hart_arb_picker: grant selection between fetch and data requests
// ARVI_ARB_ROUND_ROBIN_EN adds a last-grant register and alternates on collisions
module hart_arb_picker
   import arvi_arb_pkg::*;
(
`ifdef ARVI_ARB_ROUND_ROBIN_EN
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        take,
`endif
   input  logic        ic_req,
   input  logic        dm_req,
   output arb_master_t grant
);
`ifdef ARVI_ARB_ROUND_ROBIN_EN
   arb_master_t last;
   always_ff @(posedge i_clk or negedge i_rst)
      if (!i_rst) last <= M_IC;
      else if (take) last <= grant;
   assign grant = (ic_req && !dm_req) ? M_IC :
                  (dm_req && !ic_req) ? M_DM :
                  (last == M_DM) ? M_IC : M_DM;
`else
   assign grant = (ic_req && !dm_req) ? M_IC : M_DM;
`endif
endmodule

// File: rtl/hart_mem_arbiter.sv
// hart_mem_arbiter: merges hart fetch (IC) and data (DM) ports onto one memory bus
// ARVI_ARB_ROUND_ROBIN_EN selects round-robin instead of DM-priority arbitration
module hart_mem_arbiter
   import arvi_arb_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int BE_W = XLEN/8
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_IC_DataReq,
   input  logic [XLEN-1:0] i_IM_Addr,
   output logic            o_IC_MemReady,
   output logic [XLEN-1:0] o_IM_Instr,
   input  logic            i_DM_MemRead,
   input  logic            i_DM_Wen,
   input  logic [XLEN-1:0] i_DM_Addr,
   input  logic [XLEN-1:0] i_DM_Wd,
   input  logic [BE_W-1:0] i_DM_byte_en,
   output logic            o_DM_data_ready,
   output logic [XLEN-1:0] o_DM_ReadData,
   output logic            o_MEM_req,
   output logic            o_MEM_we,
   output logic [XLEN-1:0] o_MEM_addr,
   output logic [XLEN-1:0] o_MEM_wdata,
   output logic [BE_W-1:0] o_MEM_be,
   input  logic            i_MEM_ack,
   input  logic [XLEN-1:0] i_MEM_rdata
);
   arb_state_t  state, state_nxt;
   arb_master_t gnt, pick;
   logic        dm_req, take;

   assign dm_req = i_DM_MemRead | i_DM_Wen;
   assign take   = (state == IDLE) && (i_IC_DataReq || dm_req);

   hart_arb_picker u_picker (
`ifdef ARVI_ARB_ROUND_ROBIN_EN
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .take   (take),
`endif
      .ic_req (i_IC_DataReq),
      .dm_req (dm_req),
      .grant  (pick)
   );

   always_ff @(posedge i_clk or negedge i_rst)
      if (!i_rst) state <= IDLE;
      else state <= state_nxt;

   always_comb begin
      state_nxt = state;
      state_nxt = take ? BUSY :
                  (state == BUSY && i_MEM_ack) ? RESP :
                  (state == RESP) ? IDLE : state;
   end

   // The completing read data lands in the granted master's register; write data is a don't-care
   always_ff @(posedge i_clk or negedge i_rst)
      if (!i_rst) begin
         o_MEM_req     <= 1'b0;
         o_MEM_we      <= 1'b0;
         o_MEM_addr    <= '0;
         o_MEM_wdata   <= '0;
         o_MEM_be      <= '0;
         o_IM_Instr    <= '0;
         o_DM_ReadData <= '0;
         gnt           <= M_IC;
      end else if (take) begin
         o_MEM_req   <= 1'b1;
         gnt         <= pick;
         o_MEM_we    <= (pick == M_DM) && i_DM_Wen;
         o_MEM_addr  <= (pick == M_DM) ? i_DM_Addr : i_IM_Addr;
         o_MEM_wdata <= (pick == M_DM) ? i_DM_Wd : '0;
         o_MEM_be    <= (pick == M_DM) ? i_DM_byte_en : BE_ALL_ONES[BE_W-1:0];
      end else if (state == BUSY && i_MEM_ack) begin
         o_MEM_req <= 1'b0;
         if (gnt == M_IC) o_IM_Instr <= i_MEM_rdata;
         else o_DM_ReadData <= i_MEM_rdata;
      end

   assign o_IC_MemReady   = (state == RESP) && (gnt == M_IC);
   assign o_DM_data_ready = (state == RESP) && (gnt == M_DM);
endmodule

// File: tb/tb_hart_mem_arbiter.sv
// tb_hart_mem_arbiter: scoreboard bench with a memory responder model
module tb_hart_mem_arbiter;
   typedef struct packed {logic [31:0] addr; logic we; logic [31:0] wdata; logic [3:0] be;} mem_t;
   typedef struct packed {logic dm; logic [31:0] data;} rsp_t;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        i_IC_DataReq, i_DM_MemRead, i_DM_Wen, i_MEM_ack;
   logic [31:0] i_IM_Addr, i_DM_Addr, i_DM_Wd, i_MEM_rdata;
   logic [3:0]  i_DM_byte_en;
   logic        o_IC_MemReady, o_DM_data_ready, o_MEM_req, o_MEM_we;
   logic [31:0] o_IM_Instr, o_DM_ReadData, o_MEM_addr, o_MEM_wdata;
   logic [3:0]  o_MEM_be;

   int tests = 0, fails = 0;
   int cyc = 0, ack_dly = 2, stray_req = 0;
   int req_cyc, rise_cyc, ack_cyc, rdy_cyc;
   mem_t exp_mem[$];
   rsp_t exp_rsp[$];

   hart_mem_arbiter #(.XLEN(32), .BE_W(4)) dut (
      .i_clk(clk), .i_rst(i_rst),
      .i_IC_DataReq(i_IC_DataReq), .i_IM_Addr(i_IM_Addr),
      .o_IC_MemReady(o_IC_MemReady), .o_IM_Instr(o_IM_Instr),
      .i_DM_MemRead(i_DM_MemRead), .i_DM_Wen(i_DM_Wen), .i_DM_Addr(i_DM_Addr),
      .i_DM_Wd(i_DM_Wd), .i_DM_byte_en(i_DM_byte_en),
      .o_DM_data_ready(o_DM_data_ready), .o_DM_ReadData(o_DM_ReadData),
      .o_MEM_req(o_MEM_req), .o_MEM_we(o_MEM_we), .o_MEM_addr(o_MEM_addr),
      .o_MEM_wdata(o_MEM_wdata), .o_MEM_be(o_MEM_be),
      .i_MEM_ack(i_MEM_ack), .i_MEM_rdata(i_MEM_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return (a == 32'h100) ? 32'h13 : (a ^ 32'hA5A5_0000);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic exp_fetch(input logic [31:0] a);
      exp_mem.push_back('{a, 1'b0, 32'h0, 4'hF});
      exp_rsp.push_back('{1'b0, mem_data(a)});
   endtask

   task automatic exp_dm(input logic wen, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
      exp_mem.push_back('{a, wen, wd, be});
      exp_rsp.push_back('{1'b1, mem_data(a)});
   endtask

   task automatic drive_fetch(input logic [31:0] a);
      i_IM_Addr = a;
      i_IC_DataReq = 1'b1;
   endtask

   task automatic drive_dm(input logic rd, input logic wen, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
      i_DM_MemRead = rd;
      i_DM_Wen = wen;
      i_DM_Addr = a;
      i_DM_Wd = wd;
      i_DM_byte_en = be;
   endtask

   task automatic wait_rsp(input int n);
      int got = 0;
      for (int k = 0; k < 100 && got < n; k++) begin
         @(negedge clk);
         if (o_IC_MemReady) begin got++; i_IC_DataReq = 1'b0; end
         if (o_DM_data_ready) begin got++; i_DM_MemRead = 1'b0; i_DM_Wen = 1'b0; end
      end
      chk("rsp_count", got, n);
   endtask

   task automatic wait_req();
      for (int k = 0; k < 50 && !o_MEM_req; k++) @(negedge clk);
      chk("req_seen", {31'b0, o_MEM_req}, 1);
   endtask

   task automatic chk_lat();
      chk("req_lat", rise_cyc, req_cyc + 1);
      chk("rdy_lat", rdy_cyc, ack_cyc + 1);
      chk("total_lat", rdy_cyc, req_cyc + 2 + ack_dly);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_req"}, {31'b0, o_MEM_req}, 0);
      chk({tag, "_we"}, {31'b0, o_MEM_we}, 0);
      chk({tag, "_addr"}, o_MEM_addr, 0);
      chk({tag, "_wdata"}, o_MEM_wdata, 0);
      chk({tag, "_be"}, {28'b0, o_MEM_be}, 0);
      chk({tag, "_rdy"}, {30'b0, o_IC_MemReady, o_DM_data_ready}, 0);
      chk({tag, "_instr"}, o_IM_Instr, 0);
      chk({tag, "_rdata"}, o_DM_ReadData, 0);
   endtask

   // Memory model: acks ack_dly cycles after seeing a request, abandons it on reset
   initial begin
      int stray_done = 0;
      i_MEM_ack = 1'b0;
      i_MEM_rdata = '0;
      forever begin
         @(negedge clk);
         if (stray_req != stray_done) begin
            stray_done++;
            i_MEM_ack = 1'b1;
            i_MEM_rdata = 32'hBAD0_BAD0;
            @(negedge clk);
            i_MEM_ack = 1'b0;
         end else if (i_rst && o_MEM_req) begin
            for (int k = 0; k < ack_dly && i_rst; k++) @(negedge clk);
            if (i_rst) begin
               i_MEM_ack = 1'b1;
               i_MEM_rdata = mem_data(o_MEM_addr);
               ack_cyc = cyc;
               @(negedge clk);
               i_MEM_ack = 1'b0;
            end
         end
      end
   end

   initial begin
      logic req_prev = 1'b0;
      mem_t m;
      rsp_t r;
      forever begin
         @(negedge clk);
         if (!i_rst) begin
            req_prev = 1'b0;
            continue;
         end
         if (o_MEM_req && !req_prev) begin
            rise_cyc = cyc;
            if (exp_mem.size() == 0) chk("mem_unexp", 1, 0);
            else begin
               m = exp_mem.pop_front();
               chk("mem_addr", o_MEM_addr, m.addr);
               chk("mem_we", {31'b0, o_MEM_we}, {31'b0, m.we});
               chk("mem_wdata", o_MEM_wdata, m.wdata);
               chk("mem_be", {28'b0, o_MEM_be}, {28'b0, m.be});
            end
         end
         req_prev = o_MEM_req;
         if (o_IC_MemReady && o_DM_data_ready) chk("rdy_both", 1, 0);
         if (o_IC_MemReady || o_DM_data_ready) begin
            rdy_cyc = cyc;
            if (exp_rsp.size() == 0) chk("rsp_unexp", 1, 0);
            else begin
               r = exp_rsp.pop_front();
               chk("rsp_master", {31'b0, o_DM_data_ready}, {31'b0, r.dm});
               chk("rsp_data", r.dm ? o_DM_ReadData : o_IM_Instr, r.data);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      i_rst = 1'b0;
      i_IC_DataReq = 1'b0;
      i_IM_Addr = '0;
      drive_dm(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (3) @(negedge clk);
      chk_zero("reset");
      i_rst = 1'b1;

      @(negedge clk);
      exp_fetch(32'h100);
      drive_fetch(32'h100);
      req_cyc = cyc;
      wait_rsp(1);
      chk_lat();

      @(negedge clk);
      exp_dm(1'b1, 32'h2000, 32'hDEAD_BEEF, 4'b0011);
      drive_dm(1'b0, 1'b1, 32'h2000, 32'hDEAD_BEEF, 4'b0011);
      req_cyc = cyc;
      wait_rsp(1);
      chk_lat();

      ack_dly = 0;
      @(negedge clk);
      exp_dm(1'b1, 32'h3004, 32'h1234_5678, 4'b1100);
      drive_dm(1'b1, 1'b1, 32'h3004, 32'h1234_5678, 4'b1100);
      req_cyc = cyc;
      wait_rsp(1);
      chk_lat();

      ack_dly = 1;
      @(negedge clk);
`ifdef ARVI_ARB_ROUND_ROBIN_EN
      exp_fetch(32'h104);
      exp_dm(1'b0, 32'h4000, 32'h0, 4'hF);
`else
      exp_dm(1'b0, 32'h4000, 32'h0, 4'hF);
      exp_fetch(32'h104);
`endif
      drive_fetch(32'h104);
      drive_dm(1'b1, 1'b0, 32'h4000, 32'h0, 4'hF);
      wait_rsp(2);

      ack_dly = 3;
      @(negedge clk);
      exp_dm(1'b0, 32'h5000, 32'h0, 4'h7);
      drive_dm(1'b1, 1'b0, 32'h5000, 32'h0, 4'h7);
      wait_req();
      i_DM_MemRead = 1'b0;
      wait_rsp(1);

      ack_dly = 1;
      stray_req++;
      repeat (5) @(negedge clk);
      chk("stray_req", {31'b0, o_MEM_req}, 0);
      chk("stray_instr", o_IM_Instr, mem_data(32'h104));
      exp_fetch(32'h108);
      drive_fetch(32'h108);
      req_cyc = cyc;
      wait_rsp(1);
      chk_lat();

      ack_dly = 20;
      @(negedge clk);
      exp_fetch(32'h10C);
      drive_fetch(32'h10C);
      wait_req();
      #2 i_rst = 1'b0;
      i_IC_DataReq = 1'b0;
      #1 chk_zero("midrst");
      exp_rsp.delete();
      exp_mem.delete();
      @(negedge clk);
      i_rst = 1'b1;
      ack_dly = 1;
      @(negedge clk);
      exp_fetch(32'h100);
      drive_fetch(32'h100);
      req_cyc = cyc;
      wait_rsp(1);
      chk_lat();

      repeat (3) @(negedge clk);
      chk("rsp_left", exp_rsp.size(), 0);
      chk("mem_left", exp_mem.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
